// File: rtl/mult_unit_pkg.sv
// ============================================================================
// mult_unit_pkg
// Shared decoder function codes, FSM state encodings and default width for
// the iterative multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mult_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mult_step.sv
// ============================================================================
// mult_step
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// running HI and shift {HI, multiplier} right by one bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_step
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] mplr,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] next_acc_hi,
  output logic [WIDTH-1:0] next_mplr
);

  logic [WIDTH:0] w_sum;

  // The carry lands in the top bit of HI after the shift, so nothing is lost.
  assign w_sum       = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign next_acc_hi = w_sum[WIDTH:1];
  assign next_mplr   = {w_sum[0], mplr[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/mult_unit.sv
// ============================================================================
// mult_unit
// Iterative unsigned WIDTHxWIDTH multiplier with HI/LO result registers and a
// stall output for conflicting accesses while a multiply is in flight.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_en,
  input  logic             lohi,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int                c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_next_acc_hi;
  logic [WIDTH-1:0]   w_next_mplr;
  logic               w_last;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_hi      (r_acc_hi),
    .mplr        (r_mplr),
    .mcand       (r_mcand),
    .next_acc_hi (w_next_acc_hi),
    .next_mplr   (w_next_mplr)
  );

  assign w_last = (r_state == ST_BUSY) && (r_count == c_last_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == ST_BUSY);
    done  = w_last;
    stall = (r_state == ST_BUSY) && (start || rd_en);
  end

  // HI/LO keep the previous product until the completion edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc_hi <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplr   <= b;
            r_acc_hi <= '0;
            r_count  <= '0;
          end
        end
        ST_BUSY: begin
          r_acc_hi <= w_next_acc_hi;
          r_mplr   <= w_next_mplr;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_hi <= w_next_acc_hi;
            r_lo <= w_next_mplr;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = lohi ? r_hi : r_lo;

endmodule

`default_nettype wire
